// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM stage and its MEM/WB register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

  // Data-memory access FSM: IDLE issues zero-wait accesses, WAIT holds an outstanding one.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // One MEM/WB pipeline entry.
  typedef struct packed {
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] instr;
    logic              valid;
  } wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble request replaces the entry with a NOP.
// Latency: 1 cycle, updates every cycle (no hold/enable).
// Backpressure: none; stalls upstream are expressed by the caller as bubbles.
// Ports: clk/rst (sync, active-high), bubble_i squashes this cycle's entry,
//        wb_i next entry (valid field ignored), wb_o registered entry.
module mem_wb_reg
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bubble_i,
  input  wb_t  wb_i,
  output wb_t  wb_o
);

  wb_t wb_d;
  wb_t wb_q;

  always_comb begin
    wb_d       = wb_i;
    wb_d.valid = 1'b1;
    if (bubble_i) begin
      // Result is left as computed; it is meaningless while valid is low.
      wb_d.reg_write = 1'b0;
      wb_d.write_reg = '0;
      wb_d.instr     = NOP_INSTR;
      wb_d.valid     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_o = wb_q;

endmodule

// File: rtl/mem_stage_dmem.sv
// MIPS MEM stage: data-memory access over req/ack, result mux, MEM/WB register.
// Latency: M->W is 1 cycle plus memory wait cycles; misaligned/timeout give a 1-cycle bubble.
// Backpressure: StallM holds EX/MEM and earlier while a request is outstanding (comb from ack).
// Ports: clk/rst; EX/MEM inputs (RegWriteM, MemtoRegM, MemWriteM, MEM_Link, WriteRegM,
//        MEM_ALUOut, MEM_WriteData, MEM_PCPlus4, MEM_Instr); dmem_* memory handshake;
//        StallM; WB outputs (RegWriteW, WriteRegW, WB_Result, WB_Instr, WB_Valid);
//        Err sticky flags [0] misaligned, [1] timeout.
module mem_stage_dmem
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic              MEM_Link,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic [DATA_W-1:0] MEM_ALUOut,
  input  logic [DATA_W-1:0] MEM_WriteData,
  input  logic [DATA_W-1:0] MEM_PCPlus4,
  input  logic [DATA_W-1:0] MEM_Instr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic [DATA_W-1:0] WB_Result,
  output logic [DATA_W-1:0] WB_Instr,
  output logic              WB_Valid,
  output logic [1:0]        Err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [1:0] err_q;

  logic access;
  logic misal;
  logic at_limit;
  logic abandon;
  logic bubble;
  wb_t  wb_d;
  wb_t  wb_q;

  assign access   = MemtoRegM | MemWriteM;
  assign misal    = access & (MEM_ALUOut[1:0] != 2'b00);
  assign at_limit = (state_q == WAIT) && (cnt_q == TIMEOUT_C);

  // Request is suppressed during reset so an access in flight is dropped immediately.
  assign dmem_req   = ~rst & (((state_q == IDLE) & access & ~misal) | (state_q == WAIT));
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = MEM_ALUOut;
  assign dmem_wdata = MEM_WriteData;

  // The last WAIT cycle is not a stall: the access is abandoned and the pipe moves on.
  assign StallM  = dmem_req & ~dmem_ack & ~at_limit;
  assign abandon = ~rst & at_limit & ~dmem_ack;
  assign bubble  = StallM | abandon | misal;

  always_comb begin
    wb_d           = '0;
    wb_d.reg_write = RegWriteM;
    wb_d.write_reg = WriteRegM;
    wb_d.instr     = MEM_Instr;
    if (MEM_Link) begin
      wb_d.result = MEM_PCPlus4;
    end else if (MemtoRegM) begin
      wb_d.result = dmem_rdata;
    end else begin
      wb_d.result = MEM_ALUOut;
    end
  end

  // Access FSM, wait counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      if (misal) begin
        err_q[0] <= 1'b1;
      end
      if (abandon) begin
        err_q[1] <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (dmem_req & ~dmem_ack) begin
            state_q <= WAIT;
            cnt_q   <= 8'd1;
          end
        end
        WAIT: begin
          if (dmem_ack | at_limit) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (bubble),
    .wb_i     (wb_d),
    .wb_o     (wb_q)
  );

  assign RegWriteW = wb_q.reg_write;
  assign WriteRegW = wb_q.write_reg;
  assign WB_Result = wb_q.result;
  assign WB_Instr  = wb_q.instr;
  assign WB_Valid  = wb_q.valid;
  assign Err       = err_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem with a short timeout.
// Inputs change on the falling edge; comb outputs are sampled 1ns later,
// registered outputs 1ns after the rising edge.
module tb_mem_stage_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemtoRegM, MemWriteM, MEM_Link;
  logic [4:0]  WriteRegM;
  logic [31:0] MEM_ALUOut, MEM_WriteData, MEM_PCPlus4, MEM_Instr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        StallM, RegWriteW, WB_Valid;
  logic [4:0]  WriteRegW;
  logic [31:0] WB_Result, WB_Instr;
  logic [1:0]  Err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_dmem #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .RegWriteM     (RegWriteM),
    .MemtoRegM     (MemtoRegM),
    .MemWriteM     (MemWriteM),
    .MEM_Link      (MEM_Link),
    .WriteRegM     (WriteRegM),
    .MEM_ALUOut    (MEM_ALUOut),
    .MEM_WriteData (MEM_WriteData),
    .MEM_PCPlus4   (MEM_PCPlus4),
    .MEM_Instr     (MEM_Instr),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .StallM        (StallM),
    .RegWriteW     (RegWriteW),
    .WriteRegW     (WriteRegW),
    .WB_Result     (WB_Result),
    .WB_Instr      (WB_Instr),
    .WB_Valid      (WB_Valid),
    .Err           (Err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_m(input logic rw, input logic m2r, input logic mw, input logic lnk,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc4, input logic [31:0] ins);
    RegWriteM     = rw;
    MemtoRegM     = m2r;
    MemWriteM     = mw;
    MEM_Link      = lnk;
    WriteRegM     = wr;
    MEM_ALUOut    = alu;
    MEM_WriteData = wd;
    MEM_PCPlus4   = pc4;
    MEM_Instr     = ins;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    // Aligned load presented during reset: request must stay low.
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0010, 32'h0, 32'h0, 32'h8C03_0010);
    to_neg();
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, StallM}, 32'd0);
    after_pos();
    chk("rst_rw", {31'b0, RegWriteW}, 32'd0);
    chk("rst_wreg", {27'b0, WriteRegW}, 32'd0);
    chk("rst_res", WB_Result, 32'd0);
    chk("rst_instr", WB_Instr, 32'd0);
    chk("rst_valid", {31'b0, WB_Valid}, 32'd0);
    chk("rst_err", {30'b0, Err}, 32'd0);

    // ALU op: one-cycle pass-through, no request.
    to_neg();
    rst = 1'b0;
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_1234, 32'h0, 32'h0, 32'h2008_1234);
    #1;
    chk("alu_req", {31'b0, dmem_req}, 32'd0);
    chk("alu_stall", {31'b0, StallM}, 32'd0);
    after_pos();
    chk("alu_rw", {31'b0, RegWriteW}, 32'd1);
    chk("alu_wreg", {27'b0, WriteRegW}, 32'd8);
    chk("alu_res", WB_Result, 32'h0000_1234);
    chk("alu_valid", {31'b0, WB_Valid}, 32'd1);
    chk("alu_instr", WB_Instr, 32'h2008_1234);

    // jal: link value wins over ALU result.
    to_neg();
    set_m(1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 32'h0000_0999, 32'h0, 32'h0000_0040, 32'h0C00_0010);
    after_pos();
    chk("jal_res", WB_Result, 32'h0000_0040);
    chk("jal_wreg", {27'b0, WriteRegW}, 32'd31);

    // lw 0x100, ack on the 4th cycle: 3 stall cycles, 3 bubbles, then the data.
    for (int k = 0; k < 4; k++) begin
      to_neg();
      set_m(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0100, 32'h0, 32'h0, 32'h8C09_0100);
      dmem_ack   = (k == 3);
      dmem_rdata = (k == 3) ? 32'hDEAD_BEEF : 32'h1111_1111;
      #1;
      chk("lw_req", {31'b0, dmem_req}, 32'd1);
      chk("lw_we", {31'b0, dmem_we}, 32'd0);
      chk("lw_addr", dmem_addr, 32'h0000_0100);
      chk("lw_stall", {31'b0, StallM}, (k < 3) ? 32'd1 : 32'd0);
      after_pos();
      chk("lw_valid", {31'b0, WB_Valid}, (k == 3) ? 32'd1 : 32'd0);
      chk("lw_rw", {31'b0, RegWriteW}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        chk("lw_res", WB_Result, 32'hDEAD_BEEF);
        chk("lw_wreg", {27'b0, WriteRegW}, 32'd9);
      end
    end

    // sw 0x200 with zero-wait ack: no stall, write strobe high.
    to_neg();
    set_m(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0200, 32'h0000_CAFE, 32'h0, 32'hAC0A_0200);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0;
    #1;
    chk("sw_req", {31'b0, dmem_req}, 32'd1);
    chk("sw_we", {31'b0, dmem_we}, 32'd1);
    chk("sw_wdata", dmem_wdata, 32'h0000_CAFE);
    chk("sw_stall", {31'b0, StallM}, 32'd0);
    after_pos();
    chk("sw_valid", {31'b0, WB_Valid}, 32'd1);
    chk("sw_rw", {31'b0, RegWriteW}, 32'd0);

    // Misaligned lw 0x102: no request, squashed, Err[0].
    to_neg();
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0102, 32'h0, 32'h0, 32'h8C0A_0102);
    dmem_ack = 1'b0;
    #1;
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, StallM}, 32'd0);
    after_pos();
    chk("mis_valid", {31'b0, WB_Valid}, 32'd0);
    chk("mis_rw", {31'b0, RegWriteW}, 32'd0);
    chk("mis_instr", WB_Instr, 32'd0);
    chk("mis_err", {30'b0, Err}, 32'd1);

    // Timeout (4): stall four cycles, fifth cycle abandons with Err[1].
    for (int k = 0; k < 5; k++) begin
      to_neg();
      set_m(1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 32'h0000_0300, 32'h0, 32'h0, 32'h8C0B_0300);
      #1;
      chk("to_req", {31'b0, dmem_req}, 32'd1);
      chk("to_stall", {31'b0, StallM}, (k < 4) ? 32'd1 : 32'd0);
      after_pos();
      chk("to_valid", {31'b0, WB_Valid}, 32'd0);
      chk("to_err", {30'b0, Err}, (k < 4) ? 32'd1 : 32'd3);
    end
    // Back in IDLE: a plain ALU op issues no request and completes.
    to_neg();
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0000_0055, 32'h0, 32'h0, 32'h200C_0055);
    #1;
    chk("post_to_req", {31'b0, dmem_req}, 32'd0);
    after_pos();
    chk("post_to_valid", {31'b0, WB_Valid}, 32'd1);
    chk("post_to_res", WB_Result, 32'h0000_0055);

    // Reset while waiting, late ack afterwards must not reach WB.
    for (int k = 0; k < 2; k++) begin
      to_neg();
      set_m(1'b1, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0000_0400, 32'h0, 32'h0, 32'h8C0D_0400);
      #1;
      chk("rw_stall", {31'b0, StallM}, 32'd1);
      after_pos();
    end
    to_neg();
    rst = 1'b1;
    #1;
    chk("rw_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rw_rst_stall", {31'b0, StallM}, 32'd0);
    after_pos();
    chk("rw_rst_err", {30'b0, Err}, 32'd0);
    chk("rw_rst_valid", {31'b0, WB_Valid}, 32'd0);
    to_neg();
    rst = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("late_req", {31'b0, dmem_req}, 32'd0);
    chk("late_stall", {31'b0, StallM}, 32'd0);
    after_pos();
    chk("late_rw", {31'b0, RegWriteW}, 32'd0);
    chk("late_res", WB_Result, 32'd0);
    chk("late_err", {30'b0, Err}, 32'd0);

    to_neg();
    dmem_ack = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
